gcd_binary_engine: RTL and testbench



---
 rtl/gcd_binary_engine_pkg.sv | 6 +
 rtl/gcd_binary_engine_if.sv | 17 +
 rtl/gcd_binary_engine_sub_swap.sv | 14 +
 rtl/gcd_binary_engine.sv | 78 +++++++
 tb/tb_gcd_binary_engine.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/gcd_binary_engine_pkg.sv
// gcd_binary_engine_pkg: shared state encoding and width constants for the binary GCD engine
package gcd_pkg;
  localparam int GCD_WIDTH = 32;
  localparam int CYCLE_CNT_W = 16;
  typedef enum logic [1:0] {IDLE, ALIGN, SUBT, DONE} gcd_state_e;
endpackage

// File: rtl/gcd_binary_engine_if.sv
// gcd_binary_engine_if: start/done request bus; with GCD_CYCLE_COUNT_EN it also carries the cycle count
interface gcd_binary_engine_if import gcd_pkg::*; #(parameter int WIDTH = GCD_WIDTH) ();
  logic start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic busy;
  logic done;
  logic [WIDTH-1:0] result;
`ifdef GCD_CYCLE_COUNT_EN
  logic [CYCLE_CNT_W-1:0] cycles;
  modport master (output start, a_in, b_in, input busy, done, result, cycles);
  modport slave (input start, a_in, b_in, output busy, done, result, cycles);
`else
  modport master (output start, a_in, b_in, input busy, done, result);
  modport slave (input start, a_in, b_in, output busy, done, result);
`endif
endinterface

// File: rtl/gcd_binary_engine_sub_swap.sv
// gcd_sub_swap: one subtract-and-swap step of Stein's algorithm (a odd, b reduced towards zero)
module gcd_sub_swap #(parameter int WIDTH = gcd_pkg::GCD_WIDTH) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_a_nxt,
  output logic [WIDTH-1:0] o_b_nxt,
  output logic             o_b_zero
);
  logic w_gt;
  assign w_gt = i_a > i_b;
  assign o_b_zero = i_b == '0;
  assign o_a_nxt = (i_b[0] && w_gt) ? i_b : i_a;
  assign o_b_nxt = !i_b[0] ? i_b >> 1 : w_gt ? i_a - i_b : i_b - i_a;
endmodule

// File: rtl/gcd_binary_engine.sv
// gcd_binary_engine: binary GCD responder on a start/done bus; GCD_CYCLE_COUNT_EN adds a saturating cycle counter
module gcd_binary_engine import gcd_pkg::*; #(
  parameter int WIDTH = GCD_WIDTH,
  parameter int KW = $clog2(WIDTH) + 1
) (
  input logic clk,
  input logic reset,
  gcd_binary_engine_if.slave bus
);
  gcd_state_e r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_result, w_a_nxt, w_b_nxt, w_result_nxt, w_sub_a, w_sub_b;
  logic [KW-1:0] r_k, w_k_nxt;
  logic w_b_zero, w_both_even, w_zero_op;
  assign w_both_even = !r_a[0] && !r_b[0];
  assign w_zero_op = bus.a_in == '0 || bus.b_in == '0;
  gcd_sub_swap #(.WIDTH(WIDTH)) u_sub (
    .i_a(r_a), .i_b(r_b), .o_a_nxt(w_sub_a), .o_b_nxt(w_sub_b), .o_b_zero(w_b_zero)
  );
  // next state and datapath values for every FSM state
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt = r_a;
    w_b_nxt = r_b;
    w_k_nxt = r_k;
    w_result_nxt = r_result;
    case (r_state)
      IDLE: if (bus.start) begin
        w_a_nxt = bus.a_in;
        w_b_nxt = bus.b_in;
        w_k_nxt = '0;
        w_result_nxt = w_zero_op ? bus.a_in | bus.b_in : r_result;
        w_state_nxt = w_zero_op ? DONE : ALIGN;
      end
      ALIGN: begin
        w_a_nxt = r_a[0] ? r_a : r_a >> 1;
        w_b_nxt = w_both_even ? r_b >> 1 : r_b;
        w_k_nxt = w_both_even ? r_k + KW'(1) : r_k;
        w_state_nxt = r_a[0] ? SUBT : ALIGN;
      end
      SUBT: begin
        w_a_nxt = w_sub_a;
        w_b_nxt = w_sub_b;
        w_result_nxt = w_b_zero ? r_a << r_k : r_result;
        w_state_nxt = w_b_zero ? DONE : SUBT;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  // state and datapath registers, cleared immediately on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_a <= '0;
      r_b <= '0;
      r_k <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_a <= w_a_nxt;
      r_b <= w_b_nxt;
      r_k <= w_k_nxt;
      r_result <= w_result_nxt;
    end
  end
  assign bus.busy = r_state != IDLE;
  assign bus.done = r_state == DONE;
  assign bus.result = r_result;
`ifdef GCD_CYCLE_COUNT_EN
  logic [CYCLE_CNT_W-1:0] r_cycles;
  // the accepting cycle counts as one; every busy cycle adds one, saturating, then holds in IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cycles <= '0;
    else if (r_state == IDLE && bus.start) r_cycles <= CYCLE_CNT_W'(1);
    else if (r_state != IDLE && r_cycles != '1) r_cycles <= r_cycles + CYCLE_CNT_W'(1);
  end
  assign bus.cycles = r_cycles;
`endif
endmodule

// File: tb/tb_gcd_binary_engine.sv
// tb_gcd_binary_engine: directed vector table plus handshake corner sequences for gcd_binary_engine
module tb_gcd_binary_engine;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  gcd_binary_engine_if #(.WIDTH(32)) bus ();
  gcd_binary_engine #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  typedef struct {logic [31:0] a; logic [31:0] b; logic [31:0] exp;} vec_t;
  vec_t vecs[13];

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] euclid(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.done !== 1'b1 && lat < 140);
    chk("done_seen", bus.done, 1);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, output logic [31:0] res, output int lat);
    int d0;
    @(negedge clk);
    bus.a_in = a;
    bus.b_in = b;
    bus.start = 1;
    d0 = done_cnt;
    @(posedge clk);
    #1 bus.start = 0;
    chk("busy_on", bus.busy, 1);
    wait_done(lat);
    res = bus.result;
    @(negedge clk);
    chk("done_pulses", done_cnt - d0, 1);
    chk("busy_off", bus.busy, 0);
    chk("result_held", bus.result, res);
  endtask

  initial begin
    logic [31:0] res, ra, rb;
    int lat, d0;
    bus.start = 0;
    bus.a_in = 0;
    bus.b_in = 0;
    vecs[0] = '{32'd12, 32'd18, 32'd6};
    vecs[1] = '{32'd0, 32'd35, 32'd35};
    vecs[2] = '{32'd35, 32'd0, 32'd35};
    vecs[3] = '{32'd0, 32'd0, 32'd0};
    vecs[4] = '{32'hFFFFFFFF, 32'h80000000, 32'd1};
    vecs[5] = '{32'h80000000, 32'h80000000, 32'h80000000};
    vecs[6] = '{32'd48, 32'd180, 32'd12};
    vecs[7] = '{32'd21, 32'd14, 32'd7};
    vecs[8] = '{32'd1, 32'd1, 32'd1};
    vecs[9] = '{32'd17, 32'd289, 32'd17};
    vecs[10] = '{32'd1024, 32'd96, 32'd32};
    vecs[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[12] = '{32'd270, 32'd192, 32'd6};
    repeat (2) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_result", bus.result, 0);
    reset = 0;
    for (int i = 0; i < 13; i++) begin
      run(vecs[i].a, vecs[i].b, res, lat);
      chk("result", res, vecs[i].exp);
      chk("latency_bound", 32'(lat <= 132), 1);
      if (vecs[i].a == 0 || vecs[i].b == 0) chk("zero_latency", lat, 1);
    end
`ifdef GCD_CYCLE_COUNT_EN
    run(32'd0, 32'd9, res, lat);
    chk("cycles_zero_op", 32'(bus.cycles), 2);
`endif
    @(negedge clk);
    bus.a_in = 48;
    bus.b_in = 180;
    bus.start = 1;
    d0 = done_cnt;
    @(negedge clk);
    bus.start = 0;
    @(negedge clk);
    bus.a_in = 7;
    bus.b_in = 13;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    wait_done(lat);
    chk("ignored_start_result", bus.result, 12);
    repeat (5) @(negedge clk);
    chk("ignored_start_pulses", done_cnt - d0, 1);
    @(negedge clk);
    bus.a_in = 48;
    bus.b_in = 180;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    @(negedge clk);
    reset = 1;
    #1;
    chk("midreset_busy", bus.busy, 0);
    chk("midreset_done", bus.done, 0);
    chk("midreset_result", bus.result, 0);
    d0 = done_cnt;
    @(negedge clk);
    reset = 0;
    repeat (140) @(negedge clk);
    chk("midreset_no_done", done_cnt - d0, 0);
    run(32'd21, 32'd14, res, lat);
    chk("after_reset_result", res, 7);
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) ra = ra & 32'h0000FFF0;
      if (i % 4 == 0) rb = rb << (i % 17);
      run(ra, rb, res, lat);
      chk("random_result", res, euclid(ra, rb));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
